mips_pipe3_core: RTL

Parametrised successor to the team's 3-stage MIPS pipeline (IF / ID / EX with write-back at the end of EX). It adds an asynchronous active-low reset and an external instruction-memory port. It also adds logical immediates and `beq`/`bne` with taken-branch flush, plus a debug register-read port. RAW hazard handling is selectable: full ID-stage forwarding, or interlock with a one-cycle stall.

---
 rtl/mips_pipe3_core.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/mips_pipe3_core.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mips_pipe3_core : 3-stage MIPS pipeline (IF / ID / EX+WB) with external  |
// |   instruction memory, beq/bne flush and a debug register-read port.      |
// |   Optional feature macro: MIPS_PIPE3_FORWARDING_EN (ID-stage forwarding; |
// |   when undefined a one-cycle interlock is used instead).                 |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module mips_pipe3_core #(
  parameter logic [31:0] RESET_PC = 32'd0,
  parameter int          IMEM_AW  = 10
) (
  input  logic               clock,
  input  logic               reset_n,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_rdata,
  input  logic [4:0]         dbg_raddr,
  output logic [31:0]        dbg_rdata,
  output logic [31:0]        pc,
  output logic [31:0]        ifid_ir,
  output logic [31:0]        idex_ir,
  output logic               wb_en,
  output logic [4:0]         wb_addr,
  output logic [31:0]        wb_data,
  output logic               stall,
  output logic               flush
);

  localparam logic [5:0] c_OP_RTYPE = 6'h00;
  localparam logic [5:0] c_OP_BEQ   = 6'h04;
  localparam logic [5:0] c_OP_BNE   = 6'h05;
  localparam logic [5:0] c_OP_ADDI  = 6'h08;
  localparam logic [5:0] c_OP_ANDI  = 6'h0C;
  localparam logic [5:0] c_OP_ORI   = 6'h0D;
  localparam logic [5:0] c_FN_ADD   = 6'd32;
  localparam logic [5:0] c_FN_SUB   = 6'd34;
  localparam logic [5:0] c_FN_AND   = 6'd36;
  localparam logic [5:0] c_FN_OR    = 6'd37;
  localparam logic [5:0] c_FN_NOR   = 6'd39;
  localparam logic [5:0] c_FN_SLT   = 6'd42;

  logic [31:0] r_pc, r_ifid_ir, r_ifid_pc4;
  logic [31:0] r_idex_ir, r_idex_pc4, r_idex_a, r_idex_b;
  logic [31:0] r_regs [0:31];

  // ---------------- ID stage: register read and hazard detection ----------
  logic [5:0]  w_id_op;
  logic [4:0]  w_id_rs, w_id_rt;
  logic        w_id_uses_rt, w_haz_rs, w_haz_rt;
  logic [31:0] w_rf_a, w_rf_b, w_id_a, w_id_b;

  assign w_id_op      = r_ifid_ir[31:26];
  assign w_id_rs      = r_ifid_ir[25:21];
  assign w_id_rt      = r_ifid_ir[20:16];
  assign w_id_uses_rt = (w_id_op == c_OP_RTYPE) || (w_id_op == c_OP_BEQ) || (w_id_op == c_OP_BNE);
  assign w_haz_rs     = wb_en && (wb_addr == w_id_rs);
  assign w_haz_rt     = wb_en && (wb_addr == w_id_rt) && w_id_uses_rt;
  assign w_rf_a       = r_regs[w_id_rs];
  assign w_rf_b       = r_regs[w_id_rt];

`ifdef MIPS_PIPE3_FORWARDING_EN
  assign w_id_a = w_haz_rs ? wb_data : w_rf_a;
  assign w_id_b = w_haz_rt ? wb_data : w_rf_b;
  assign stall  = 1'b0;
`else
  // The register file returns the old value during a write, so wait one cycle.
  assign w_id_a = w_rf_a;
  assign w_id_b = w_rf_b;
  assign stall  = (w_haz_rs | w_haz_rt) & ~flush;
`endif

  // ---------------- EX stage: ALU, branch resolution, write-back ----------
  logic [5:0]  w_ex_op, w_ex_fn;
  logic [31:0] w_imm_sx, w_imm_zx, w_alu, w_target;
  logic [4:0]  w_dst;
  logic        w_wr, w_taken;

  assign w_ex_op  = r_idex_ir[31:26];
  assign w_ex_fn  = r_idex_ir[5:0];
  assign w_imm_sx = {{16{r_idex_ir[15]}}, r_idex_ir[15:0]};
  assign w_imm_zx = {16'd0, r_idex_ir[15:0]};
  assign w_target = r_idex_pc4 + {w_imm_sx[29:0], 2'b00};

  always_comb begin
    w_alu   = 32'd0;
    w_dst   = 5'd0;
    w_wr    = 1'b0;
    w_taken = 1'b0;
    case (w_ex_op)
      c_OP_RTYPE: begin
        w_wr  = 1'b1;
        w_dst = r_idex_ir[15:11];
        case (w_ex_fn)
          c_FN_ADD: w_alu = r_idex_a + r_idex_b;
          c_FN_SUB: w_alu = r_idex_a - r_idex_b;
          c_FN_AND: w_alu = r_idex_a & r_idex_b;
          c_FN_OR:  w_alu = r_idex_a | r_idex_b;
          c_FN_NOR: w_alu = ~(r_idex_a | r_idex_b);
          c_FN_SLT: w_alu = {31'd0, $signed(r_idex_a) < $signed(r_idex_b)};
          default: begin
            w_wr  = 1'b0;
            w_dst = 5'd0;
          end
        endcase
      end
      c_OP_ADDI: begin w_wr = 1'b1; w_dst = r_idex_ir[20:16]; w_alu = r_idex_a + w_imm_sx; end
      c_OP_ANDI: begin w_wr = 1'b1; w_dst = r_idex_ir[20:16]; w_alu = r_idex_a & w_imm_zx; end
      c_OP_ORI:  begin w_wr = 1'b1; w_dst = r_idex_ir[20:16]; w_alu = r_idex_a | w_imm_zx; end
      c_OP_BEQ:  w_taken = (r_idex_a == r_idex_b);
      c_OP_BNE:  w_taken = (r_idex_a != r_idex_b);
      default:   w_wr = 1'b0;
    endcase
  end

  assign wb_en   = w_wr && (w_dst != 5'd0);
  assign wb_addr = wb_en ? w_dst : 5'd0;
  assign wb_data = w_alu;
  assign flush   = w_taken;

  // ---------------- Pipeline registers ------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_pc       <= RESET_PC;
      r_ifid_ir  <= 32'd0;
      r_ifid_pc4 <= 32'd0;
      r_idex_ir  <= 32'd0;
      r_idex_pc4 <= 32'd0;
      r_idex_a   <= 32'd0;
      r_idex_b   <= 32'd0;
    end else begin
      if (flush) begin
        r_pc      <= w_target;
        r_ifid_ir <= 32'd0;
      end else if (!stall) begin
        r_pc       <= r_pc + 32'd4;
        r_ifid_ir  <= imem_rdata;
        r_ifid_pc4 <= r_pc + 32'd4;
      end
      // A bubble is an all-zero instruction, which decodes as a no-op.
      if (flush || stall) begin
        r_idex_ir  <= 32'd0;
        r_idex_pc4 <= 32'd0;
        r_idex_a   <= 32'd0;
        r_idex_b   <= 32'd0;
      end else begin
        r_idex_ir  <= r_ifid_ir;
        r_idex_pc4 <= r_ifid_pc4;
        r_idex_a   <= w_id_a;
        r_idex_b   <= w_id_b;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 32; i++) r_regs[i] <= 32'd0;
    end else if (wb_en) begin
      r_regs[wb_addr] <= wb_data;
    end
  end

  assign imem_addr = r_pc[IMEM_AW+1:2];
  assign dbg_rdata = (dbg_raddr == 5'd0) ? 32'd0 : r_regs[dbg_raddr];
  assign pc        = r_pc;
  assign ifid_ir   = r_ifid_ir;
  assign idex_ir   = r_idex_ir;

endmodule
`default_nettype wire
